// File: rtl/div_share_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
// FSM encoding, datapath widths and a constant clog2 helper.
package div_share_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 32;
    localparam int DOUT_W     = 48;

    // Quotient reported for a divide-by-zero when flagging is enabled
    localparam logic [DOUT_W-1:0] DBZ_DATA = 48'hFFFF_FFFF_FFFF;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_tag_fifo.sv
// In-order tag FIFO for divides in flight inside the core.
// Combinational read of the head entry; push and pop may share a cycle.
module div_tag_fifo
    import div_share_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array: contents are only observed while count says valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy tracks net pushes minus pops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one AXI-Stream divider core among NREQ requesters.
// Optional DIV_DBZ_EN: flag divide-by-zero per op and force an all-ones quotient.
module div_share_arbiter
    import div_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 8,
    parameter int IDW     = 2
) (
    input  logic                       aclk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*DIVIDEND_W-1:0] req_dividend,
    input  logic [NREQ*DIVISOR_W-1:0]  req_divisor,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DOUT_W-1:0]          rsp_data,
    output logic                       rsp_dbz,
    output logic                       err_orphan,
    output logic                       div_dividend_tvalid,
    input  logic                       div_dividend_tready,
    output logic [DIVIDEND_W-1:0]      div_dividend_tdata,
    output logic                       div_divisor_tvalid,
    input  logic                       div_divisor_tready,
    output logic [DIVISOR_W-1:0]       div_divisor_tdata,
    input  logic                       div_dout_tvalid,
    input  logic [DOUT_W-1:0]          div_dout_tdata
);

    localparam int CW = clog2(MAX_OUT) + 1;
    localparam logic [CW-1:0] MAX_CR = CW'(MAX_OUT);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] RSP_ONE = NREQ'(1);
`ifdef DIV_DBZ_EN
    localparam int TW = IDW + 1;
`else
    localparam int TW = IDW;
`endif

    state_t                state;
    state_t                state_nxt;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        win_id;
    logic [IDW-1:0]        cand;
    int                    idx;
    logic                  win_found;
    logic                  grant;
    logic [CW-1:0]         credits;
    logic [DIVIDEND_W-1:0] sel_dvd;
    logic [DIVISOR_W-1:0]  sel_dvs;
    logic [DIVIDEND_W-1:0] dvd_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic                  dvd_v;
    logic                  dvs_v;
    logic                  dvd_done;
    logic                  dvs_done;
    logic [TW-1:0]         tag_in;
    logic [TW-1:0]         tag_out;
    logic [IDW-1:0]        rsp_id;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  res_pop;
    logic                  orphan;

    assign div_dividend_tvalid = dvd_v;
    assign div_divisor_tvalid  = dvs_v;
    assign div_dividend_tdata  = dvd_q;
    assign div_divisor_tdata   = dvs_q;

    assign dvd_done = !dvd_v || div_dividend_tready;
    assign dvs_done = !dvs_v || div_divisor_tready;

    assign res_pop = div_dout_tvalid && !fifo_empty;
    assign orphan  = div_dout_tvalid && fifo_empty;
    assign rsp_id  = tag_out[IDW-1:0];

    // Winner: first valid requester at or after the rr pointer, wrapping
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IDW'(idx);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Operand mux for the current winner
    always_comb begin
        sel_dvd = '0;
        sel_dvs = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == IDW'(i)) begin
                sel_dvd = req_dividend[i*DIVIDEND_W +: DIVIDEND_W];
                sel_dvs = req_divisor[i*DIVISOR_W +: DIVISOR_W];
            end
        end
    end

    // Tag carries the requester id, plus a zero-divisor bit when enabled
    always_comb begin
`ifdef DIV_DBZ_EN
        tag_in = {(sel_dvs == '0), win_id};
`else
        tag_in = win_id;
`endif
    end

    // FSM state register
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state <= ST_ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant; no grant while in reset or out of credits
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        req_ready = '0;
        unique case (state)
            ST_ARB: begin
                if (!rst && win_found && (credits < MAX_CR)
                    && !fifo_full) begin
                    grant             = 1'b1;
                    req_ready[win_id] = 1'b1;
                    state_nxt         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dvd_done && dvs_done) begin
                    state_nxt = ST_ARB;
                end
            end
        endcase
    end

    // Round-robin pointer moves past each winner
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (win_id == LAST_ID) ? '0 : win_id + IDW'(1);
        end
    end

    // Operand issue: each channel drops tvalid after its own handshake
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            dvd_v <= 1'b0;
            dvs_v <= 1'b0;
            dvd_q <= '0;
            dvs_q <= '0;
        end else if (grant) begin
            dvd_v <= 1'b1;
            dvs_v <= 1'b1;
            dvd_q <= sel_dvd;
            dvs_q <= sel_dvs;
        end else begin
            if (dvd_v && div_dividend_tready) begin
                dvd_v <= 1'b0;
            end
            if (dvs_v && div_divisor_tready) begin
                dvs_v <= 1'b0;
            end
        end
    end

    // Credits: one per op between grant and returned result
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            credits <= '0;
        end else if (grant && !res_pop) begin
            credits <= credits + CW'(1);
        end else if (!grant && res_pop) begin
            credits <= credits - CW'(1);
        end
    end

    div_tag_fifo #(
        .DEPTH (MAX_OUT),
        .W     (TW)
    ) u_tag_fifo (
        .clk   (aclk),
        .rst   (rst),
        .push  (grant),
        .din   (tag_in),
        .pop   (res_pop),
        .dout  (tag_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Route each core result to the requester at the FIFO head
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (res_pop) begin
                rsp_valid <= RSP_ONE << rsp_id;
`ifdef DIV_DBZ_EN
                rsp_data <= tag_out[IDW] ? DBZ_DATA : div_dout_tdata;
`else
                rsp_data <= div_dout_tdata;
`endif
            end
        end
    end

`ifdef DIV_DBZ_EN
    // Divide-by-zero flag strobes alongside rsp_valid
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            rsp_dbz <= 1'b0;
        end else begin
            rsp_dbz <= res_pop && tag_out[IDW];
        end
    end
`else
    assign rsp_dbz = 1'b0;
`endif

    // Sticky flag for a core result with nothing outstanding
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (orphan) begin
            err_orphan <= 1'b1;
        end
    end

endmodule
